// File: rtl/tx_pkg.sv
// Transmit beamformer shared constants: array size, FSM encoding and the Q1.8 sine table.
package tx_pkg;
   localparam int NUM_ELEM = 64;
   localparam int SIN_FRAC = 8;
   localparam int NPTS_W   = 13;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_CALC   = 3'd1;
   localparam state_t ST_FIRE   = 3'd2;
   localparam state_t ST_LISTEN = 3'd3;
   localparam state_t ST_DONE   = 3'd4;

   // round(256*sin(deg)) for deg = 0..90
   localparam logic [SIN_FRAC:0] SIN_TAB [0:90] = '{
        0,   4,   9,  13,  18,  22,  27,  31,  36,  40,
       44,  49,  53,  58,  62,  66,  71,  75,  79,  83,
       88,  92,  96, 100, 104, 108, 112, 116, 120, 124,
      128, 132, 136, 139, 143, 147, 150, 154, 158, 161,
      165, 168, 171, 175, 178, 181, 184, 187, 190, 193,
      196, 199, 202, 204, 207, 210, 212, 215, 217, 219,
      222, 224, 226, 228, 230, 232, 234, 236, 237, 239,
      241, 242, 243, 245, 246, 247, 248, 249, 250, 251,
      252, 253, 254, 254, 255, 255, 255, 256, 256, 256,
      256
   };

   function automatic logic [SIN_FRAC:0] sin_q8(input logic [6:0] deg);
      logic [SIN_FRAC:0] v;
      v = (deg > 7'd90) ? 9'd256 : SIN_TAB[deg];
      return v;
   endfunction
endpackage

// File: rtl/transmitter_if.sv
// Scan-controller <-> transmitter bus; `busy` exists only when TX_BUSY_EN is defined.
interface transmitter_if #(
   parameter int ANGLE_DW = 8,
   parameter int DW_INPUT = 8
);
   import tx_pkg::*;

   logic                initiate;
   logic [DW_INPUT-1:0] r_0;
   logic [ANGLE_DW-1:0] angle;
   logic [NPTS_W-1:0]   num_points;
   logic [NUM_ELEM-1:0] txArray;
   logic                done;
`ifdef TX_BUSY_EN
   logic                busy;

   modport master (output initiate, r_0, angle, num_points, input txArray, done, busy);
   modport slave  (input initiate, r_0, angle, num_points, output txArray, done, busy);
`else
   modport master (output initiate, r_0, angle, num_points, input txArray, done);
   modport slave  (input initiate, r_0, angle, num_points, output txArray, done);
`endif
endinterface

// File: rtl/tx_delay_calc.sv
// Steering delay for one element: d = (m*ELEM_K*s) >> (DW_FRACTION+SIN_FRAC), m mirrored for angles below broadside.
module tx_delay_calc
   import tx_pkg::*;
#(
   parameter int DW_INTEGER  = 18,
   parameter int DW_FRACTION = 8,
   parameter int ELEM_K      = 4987
) (
   input  logic [$clog2(NUM_ELEM)-1:0] i_idx,
   input  logic                        i_rev,
   input  logic [SIN_FRAC:0]           i_s,
   output logic [DW_INTEGER-1:0]       o_d
);
   localparam int IW = $clog2(NUM_ELEM);
   localparam int PW = IW + DW_INTEGER + DW_FRACTION + SIN_FRAC + 1;

   logic [IW-1:0] w_m;
   logic [PW-1:0] w_prod;

   assign w_m    = i_rev ? (IW'(NUM_ELEM - 1) - i_idx) : i_idx;
   assign w_prod = PW'(w_m) * PW'(ELEM_K) * PW'(i_s);
   assign o_d    = DW_INTEGER'(w_prod >> (DW_FRACTION + SIN_FRAC));
endmodule

// File: rtl/transmitter.sv
// 64-element transmit beamformer: CALC fills one delay per cycle, then FIRE/LISTEN per scan point, DONE pulse.
// Optional `busy` output on the bus when TX_BUSY_EN is defined.
module transmitter
   import tx_pkg::*;
#(
   parameter int DW_INTEGER  = 18,
   parameter int DW_FRACTION = 8,
   parameter int ANGLE_DW    = 8,
   parameter int DW_INPUT    = 8,
   parameter int ELEM_K      = 4987,
   parameter int PULSE_LEN   = 4,
   parameter int DEPTH_CYC   = 8
) (
   input  logic         clk,
   input  logic         rst,
   transmitter_if.slave bus
);
   localparam int IW = $clog2(NUM_ELEM);

   state_t                r_state;
   logic [ANGLE_DW-1:0]   r_angle;
   logic [DW_INPUT-1:0]   r_r0;
   logic [NPTS_W-1:0]     r_npts;
   logic [NPTS_W-1:0]     r_p;
   logic [IW-1:0]         r_idx;
   logic [DW_INTEGER-1:0] r_dly [NUM_ELEM];
   logic [DW_INTEGER-1:0] r_dmax;
   logic [DW_INTEGER-1:0] r_t;
   logic [DW_INTEGER-1:0] r_lcnt;

   logic [ANGLE_DW-1:0]   w_angle_in;
   logic                  w_rev;
   logic [6:0]            w_theta;
   logic [SIN_FRAC:0]     w_s;
   logic [DW_INTEGER-1:0] w_d;
   logic [DW_INTEGER-1:0] w_listen_len;
   logic                  w_fire_last;
   logic                  w_listen_last;
   logic                  w_adv;
   logic [NPTS_W-1:0]     w_p_next;
   logic [NUM_ELEM-1:0]   w_tx;

   assign w_angle_in = (bus.angle > ANGLE_DW'(180)) ? ANGLE_DW'(180) : bus.angle;
   assign w_rev      = (r_angle < ANGLE_DW'(90));
   assign w_theta    = w_rev ? 7'(ANGLE_DW'(90) - r_angle) : 7'(r_angle - ANGLE_DW'(90));
   assign w_s        = sin_q8(w_theta);

   tx_delay_calc #(
      .DW_INTEGER  (DW_INTEGER),
      .DW_FRACTION (DW_FRACTION),
      .ELEM_K      (ELEM_K)
   ) u_delay_calc (
      .i_idx (r_idx),
      .i_rev (w_rev),
      .i_s   (w_s),
      .o_d   (w_d)
   );

   // Round-trip listen time for the current point: 2*(r_0+p)*DEPTH_CYC cycles
   assign w_listen_len  = DW_INTEGER'((32'(r_r0) + 32'(r_p)) * 32'(2 * DEPTH_CYC));
   assign w_fire_last   = (r_t == r_dmax + DW_INTEGER'(PULSE_LEN - 1));
   assign w_listen_last = (r_lcnt == w_listen_len - DW_INTEGER'(1));
   assign w_p_next      = r_p + NPTS_W'(1);
   // A zero-length listen window (r_0 = 0, p = 0) goes straight on to the next point
   assign w_adv = ((r_state == ST_FIRE) && w_fire_last && (w_listen_len == '0)) ||
                  ((r_state == ST_LISTEN) && w_listen_last);

   always_comb begin
      w_tx = '0;
      if (r_state == ST_FIRE) begin
         for (int i = 0; i < NUM_ELEM; i++) begin
            w_tx[i] = (r_t >= r_dly[i]) && (r_t < r_dly[i] + DW_INTEGER'(PULSE_LEN));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_angle <= '0;
         r_r0    <= '0;
         r_npts  <= '0;
         r_p     <= '0;
         r_idx   <= '0;
         r_dmax  <= '0;
         r_t     <= '0;
         r_lcnt  <= '0;
         for (int i = 0; i < NUM_ELEM; i++) begin
            r_dly[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.initiate) begin
                  r_angle <= w_angle_in;
                  r_r0    <= bus.r_0;
                  r_npts  <= bus.num_points;
                  r_p     <= '0;
                  r_idx   <= '0;
                  r_dmax  <= '0;
                  r_state <= ST_CALC;
               end
            end
            ST_CALC: begin
               r_dly[r_idx] <= w_d;
               if (w_d > r_dmax) r_dmax <= w_d;
               r_idx <= r_idx + IW'(1);
               if (r_idx == IW'(NUM_ELEM - 1)) begin
                  r_t     <= '0;
                  r_state <= (r_npts == '0) ? ST_DONE : ST_FIRE;
               end
            end
            ST_FIRE: begin
               r_t <= r_t + DW_INTEGER'(1);
               if (w_fire_last) begin
                  r_lcnt  <= '0;
                  r_state <= ST_LISTEN;
               end
            end
            ST_LISTEN: begin
               r_lcnt <= r_lcnt + DW_INTEGER'(1);
            end
            ST_DONE: begin
               r_p     <= '0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_adv) begin
            r_p     <= w_p_next;
            r_t     <= '0;
            r_state <= (w_p_next == r_npts) ? ST_DONE : ST_FIRE;
         end
      end
   end

   assign bus.txArray = w_tx;
   assign bus.done    = (r_state == ST_DONE);
`ifdef TX_BUSY_EN
   assign bus.busy    = (r_state != ST_IDLE);
`endif
endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: randomized and directed scanlines against a cycle-trace model built from sine math.
module tb_transmitter;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   transmitter_if bus_if ();

   transmitter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_delay(input int ang, input int i);
      int     a;
      int     s;
      int     m;
      real    th;
      longint prod;
      a    = (ang > 180) ? 180 : ang;
      th   = (a >= 90) ? real'(a - 90) : real'(90 - a);
      s    = $rtoi(256.0 * $sin(th * 3.141592653589793 / 180.0) + 0.5);
      m    = (a >= 90) ? i : 63 - i;
      prod = longint'(m) * 4987 * s;
      return int'(prod / 65536);
   endfunction

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   // Expected {done, txArray} for every sampled cycle, starting with the first CALC cycle
   logic [64:0] expq[$];
   int          m_fire_len;

   task automatic build_model(input int ang, input int r0, input int np);
      int          d[64];
      int          dmax;
      logic [63:0] pat;
      expq.delete();
      dmax = 0;
      for (int i = 0; i < 64; i++) begin
         d[i] = model_delay(ang, i);
         if (d[i] > dmax) dmax = d[i];
      end
      m_fire_len = dmax + 4;
      repeat (64) expq.push_back('0);
      for (int p = 0; p < np; p++) begin
         for (int t = 0; t < m_fire_len; t++) begin
            pat = '0;
            for (int i = 0; i < 64; i++) if (d[i] <= t && t < d[i] + 4) pat[i] = 1'b1;
            expq.push_back({1'b0, pat});
         end
         repeat (2 * (r0 + p) * 8) expq.push_back('0);
      end
      expq.push_back({1'b1, 64'b0});
      expq.push_back('0);
   endtask

   int          obs_done_cyc, obs_done_cnt, obs_nz, obs_first_nz, obs_hi0, obs_hi63;
   int          bad_cyc, first_bad;
   logic [63:0] obs_first_val;
   int          rise0[$], rise63[$], fall0[$];

   task automatic run_scan(input string tag, input int ang, input int r0, input int np, input bit relaunch);
      logic [64:0] obs;
      logic [63:0] prev;
      int          k_rel;
      build_model(ang, r0, np);
      obs_done_cyc = -1; obs_done_cnt = 0; obs_nz = 0; obs_first_nz = -1;
      obs_hi0 = 0; obs_hi63 = 0; bad_cyc = 0; first_bad = -1; obs_first_val = '0;
      rise0.delete(); rise63.delete(); fall0.delete();
      k_rel = 64 + m_fire_len + 2;
      @(negedge clk);
      bus_if.initiate   = 1'b1;
      bus_if.angle      = 8'(ang);
      bus_if.r_0        = 8'(r0);
      bus_if.num_points = 13'(np);
      @(negedge clk);
      bus_if.initiate = 1'b0;
      prev = '0;
      for (int k = 0; k < expq.size(); k++) begin
         obs = {bus_if.done, bus_if.txArray};
         if (obs[0] && !prev[0]) rise0.push_back(k);
         if (!obs[0] && prev[0]) fall0.push_back(k);
         if (obs[63] && !prev[63]) rise63.push_back(k);
         obs_hi0  += int'(obs[0]);
         obs_hi63 += int'(obs[63]);
         if (obs[63:0] != '0) begin
            obs_nz++;
            if (obs_first_nz < 0) begin
               obs_first_nz  = k;
               obs_first_val = obs[63:0];
            end
         end
         if (obs[64]) begin
            obs_done_cnt++;
            if (obs_done_cyc < 0) obs_done_cyc = k;
         end
         if (obs !== expq[k]) begin
            bad_cyc++;
            if (first_bad < 0) first_bad = k;
         end
`ifdef TX_BUSY_EN
         if (k == 0) check_val({tag, "_busy_run"}, 64'(bus_if.busy), 64'd1);
         if (k == expq.size() - 1) check_val({tag, "_busy_idle"}, 64'(bus_if.busy), 64'd0);
`endif
         prev = obs[63:0];
         if (relaunch && k == k_rel) begin
            bus_if.initiate   = 1'b1;
            bus_if.angle      = 8'd90;
            bus_if.r_0        = 8'd0;
            bus_if.num_points = 13'(np + 5);
         end else begin
            bus_if.initiate = 1'b0;
         end
         @(negedge clk);
      end
      check_val($sformatf("%s_trace_bad_cycles(first=%0d)", tag, first_bad), 64'(bad_cyc), 64'd0);
      check_val({tag, "_done_cycle"}, 64'(obs_done_cyc), 64'(expq.size() - 2));
      check_val({tag, "_done_count"}, 64'(obs_done_cnt), 64'd1);
   endtask

   int cnt;

   initial begin
      rst               = 1'b1;
      bus_if.initiate   = 1'b0;
      bus_if.angle      = '0;
      bus_if.r_0        = '0;
      bus_if.num_points = '0;
      repeat (3) @(negedge clk);
      check_val("reset_tx", bus_if.txArray, 64'd0);
      check_val("reset_done", 64'(bus_if.done), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_scan("a60", 60, 10, 50, 1'b0);
      check_val("a60_b63_rise", 64'(qat(rise63, 0)), 64'd64);
      check_val("a60_b0_rise", 64'(qat(rise0, 0)), 64'(64 + 613));
      check_val("a60_b0_high_total", 64'(obs_hi0), 64'd200);
      check_val("a60_b63_high_total", 64'(obs_hi63), 64'd200);
      check_val("a60_b63_firings", 64'(rise63.size()), 64'd50);
      check_val("a60_listen0", 64'(qat(rise63, 1) - qat(fall0, 0)), 64'd160);

      run_scan("a90", 90, 2, 3, 1'b0);
      check_val("a90_first_pattern", obs_first_val, '1);
      check_val("a90_first_cycle", 64'(obs_first_nz), 64'd64);
      check_val("a90_active_cycles", 64'(obs_nz), 64'd12);

      run_scan("a120", 120, 1, 1, 1'b0);
      check_val("a120_b0_rise", 64'(qat(rise0, 0)), 64'd64);
      check_val("a120_b63_rise", 64'(qat(rise63, 0)), 64'(64 + 613));

      run_scan("np0", 75, 5, 0, 1'b0);
      check_val("np0_active_cycles", 64'(obs_nz), 64'd0);

      run_scan("clamp", 250, 2, 1, 1'b0);

      // Reset in the middle of a broadside firing
      @(negedge clk);
      bus_if.initiate   = 1'b1;
      bus_if.angle      = 8'd90;
      bus_if.r_0        = 8'd3;
      bus_if.num_points = 13'd2;
      @(negedge clk);
      bus_if.initiate = 1'b0;
      repeat (65) @(negedge clk);
      check_val("pre_rst_tx", bus_if.txArray, '1);
      rst = 1'b1;
      #1;
      check_val("rst_async_tx", bus_if.txArray, 64'd0);
      check_val("rst_async_done", 64'(bus_if.done), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         cnt += int'(bus_if.done);
      end
      check_val("rst_no_done", 64'(cnt), 64'd0);
      run_scan("post_rst", 100, 3, 2, 1'b0);

      run_scan("relaunch", 80, 4, 2, 1'b1);

      for (int n = 0; n < 3; n++) begin
         run_scan($sformatf("rnd%0d", n), int'($urandom_range(60, 120)),
                  (n == 0) ? 0 : int'($urandom_range(0, 8)), int'($urandom_range(1, 3)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/transmitter.md
Name: transmitter

Overview:
- Transmit beamformer for a 64-element linear ultrasound array; sits between the scan controller and the per-element pulser drivers.
- On `initiate`, latches steering angle, first focal depth and point count.
- Computes one steering delay per element, then fires `num_points` transmit events. Each event is followed by a round-trip listen interval sized from the point's depth.
- Pulses `done` when the scanline is complete.

Parameters:
- DW_INTEGER, 18, integer bits of delay/time values in clock cycles.
- DW_FRACTION, 8, fractional bits of fixed-point element constant ELEM_K.
- ANGLE_DW, 8, width of angle input (whole degrees).
- DW_INPUT, 8, width of r_0 input.
- ELEM_K, 4987, element pitch / (c·Tclk) in Q(DW_INTEGER.DW_FRACTION); 4987 ≈ 19.48 cycles (0.3 mm, 1540 m/s, 100 MHz).
- PULSE_LEN, 4, cycles each element bit stays high per firing.
- DEPTH_CYC, 8, cycles per depth unit, one way.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- initiate  in  1  single-cycle start of a scanline; sampled only in IDLE.
- r_0  in  DW_INPUT  depth of first scan point (units).
- angle  in  ANGLE_DW  steering angle in degrees; 90 = broadside, valid 0..180.
- num_points  in  13  scan points in the scanline.
- txArray  out  64  transmit pulse per element; bit i = element i.
- done  out  1  one-cycle pulse when the scanline finishes.

Behaviour:
- Reset (async): state IDLE, txArray=0, done=0, point index p=0, all delay registers 0.
- IDLE:
  - initiate=1 latches angle (clamped to 180 if larger), r_0 and num_points, then goes to CALC.
  - initiate in any other state is ignored.
- CALC:
  - Computes θ = |angle−90| and s = SIN_LUT[θ] (Q1.8, 256 = 1.0).
  - Computes one delay per cycle, element 0..63 (64 cycles).
  - Delay: d_i = (m_i·ELEM_K·s) >> (DW_FRACTION+8), truncated to DW_INTEGER bits.
  - m_i = i when angle ≥ 90; m_i = 63−i when angle < 90.
  - Tracks dmax. Exits to FIRE, or to DONE if num_points=0.
- FIRE:
  - Counter t starts at 0 and increments each cycle.
  - txArray[i]=1 exactly while d_i ≤ t < d_i+PULSE_LEN; elements with equal delays fire in the same cycle.
  - Exits after t = dmax+PULSE_LEN−1, with txArray=0 on exit.
- LISTEN:
  - Waits exactly 2·(r_0+p)·DEPTH_CYC cycles with txArray=0.
  - Then p ← p+1. If p = num_points go to DONE, else FIRE (t reset to 0).
- DONE: done=1 for one cycle, then IDLE with p=0.
- Delays are constant across all points of a scanline; no recalculation between points.
- Arithmetic: product needs 6+DW_INTEGER+DW_FRACTION+9 bits; no overflow allowed before the shift.
- Reset mid-operation aborts immediately: txArray drops to 0 asynchronously and no done pulse is generated.

Optional Feature:
- Macro TX_BUSY_EN.
- Defined: adds output port `busy` (1 bit), high in every state except IDLE, 0 in reset. Enables back-to-back initiate scheduling by the scan controller.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Package tx_pkg:
  - NUM_ELEM=64, SIN_FRAC=8.
  - State enum {IDLE, CALC, FIRE, LISTEN, DONE}.
  - Function sin_q8(deg 0..90) returning round(256·sin) as a 91-entry constant table.
- Sub-module tx_delay_calc: serial multiply/shift unit taking element index, direction and s, producing one d_i per cycle. The top level keeps the delay register array, counters and FSM.

Test Plan:
- angle=60, r_0=10, num_points=50, initiate pulse after reset:
  - d_63=0, d_62=9, d_0=613.
  - txArray[63] rises first cycle of FIRE; bit 0 rises 613 cycles later.
  - Each bit is high 4 cycles.
  - First LISTEN is 160 cycles.
  - done pulses once after 50 firings.
- angle=90: all 64 bits rise in the same cycle for 4 cycles; FIRE lasts 4 cycles.
- angle=120: mirror of the angle=60 case — d_0=0 and d_63=613.
- num_points=0: CALC, then done pulse; txArray never nonzero.
- rst asserted mid-FIRE: txArray=0 and done=0 immediately; next initiate runs a full scanline normally.
- initiate pulsed again during LISTEN: ignored, point count unchanged, single done pulse.
